// File: rtl/irq_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// irq_sequencer_pkg
// Shared definitions for the interrupt sequencer slice:
//   IRQ_ADDR_W     default program-memory address width
//   IRQ_ID_W       width of a request-line index (up to 8 lines)
//   IRQ_CNT_W      width of the service watchdog counter
//   irq_state_t    FSM encoding (IRQ_IDLE / IRQ_SERVICE)
//   vectorAddress  vector address of a line, before truncation to the
//                  address width of the instantiating module
// -----------------------------------------------------------------------------
package irq_sequencer_pkg;

    localparam int IRQ_ADDR_W = 8;
    localparam int IRQ_ID_W   = 3;
    localparam int IRQ_CNT_W  = 8;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_SERVICE = 1'b1
    } irq_state_t;

    // Computed at full integer width; the caller truncates to its own address
    // width, which gives the modulo-2^ADDR_W wrap of the vector table.
    function automatic logic [31:0] vectorAddress(
        input logic [31:0]         base,
        input logic [IRQ_ID_W-1:0] id,
        input logic [31:0]         stride
    );
        return base + ({29'd0, id} * stride);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder for pending interrupt lines. The lowest set index
// wins; there is no rotation or fairness.
// Ports:
//   i_req    in   NUM_IRQ   pending request vector
//   o_valid  out  1         at least one request is set
//   o_idx    out  3         index of the winning (lowest) set bit
// -----------------------------------------------------------------------------
module irq_prio_enc
    import irq_sequencer_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0]  i_req,
    output logic                o_valid,
    output logic [IRQ_ID_W-1:0] o_idx
);

    // Scan from the top down so the last match, the lowest index, is the one
    // left standing.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
// Interrupt controller beside the program sequencer. Arbitrates NUM_IRQ level
// requests, redirects fetch to a per-line vector, saves the sequencer's next
// fetch address on entry and restores it on RTI. A watchdog flags services
// that run longer than TIMEOUT cycles.
// Ports:
//   i_clk           in   1        system clock
//   i_sync_reset_n  in   1        synchronous active-low reset
//   i_irq_req       in   NUM_IRQ  level requests, held until acked
//   i_irq_mask      in   NUM_IRQ  1 = line enabled
//   i_global_en     in   1        master interrupt enable
//   i_take_ok       in   1        current instruction is interruptible
//   i_rti           in   1        return-from-interrupt instruction in pc
//   i_next_addr     in   ADDR_W   sequencer's un-forced fetch address
//   o_force_jmp     out  1        override the sequencer fetch address
//   o_force_addr    out  ADDR_W   address to fetch when o_force_jmp=1
//   o_irq_ack       out  NUM_IRQ  one-hot ack, same cycle as vectoring
//   o_in_service    out  1        1 while servicing an interrupt
//   o_active_id     out  3        index of the line being serviced
//   o_watchdog_err  out  1        sticky service-timeout flag
// -----------------------------------------------------------------------------
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int                NUM_IRQ       = 4,
    parameter int                ADDR_W        = IRQ_ADDR_W,
    parameter logic [ADDR_W-1:0] VECTOR_BASE   = 'hF0,
    parameter int                VECTOR_STRIDE = 4,
    parameter int                TIMEOUT       = 255
) (
    input  logic                i_clk,
    input  logic                i_sync_reset_n,
    input  logic [NUM_IRQ-1:0]  i_irq_req,
    input  logic [NUM_IRQ-1:0]  i_irq_mask,
    input  logic                i_global_en,
    input  logic                i_take_ok,
    input  logic                i_rti,
    input  logic [ADDR_W-1:0]   i_next_addr,
    output logic                o_force_jmp,
    output logic [ADDR_W-1:0]   o_force_addr,
    output logic [NUM_IRQ-1:0]  o_irq_ack,
    output logic                o_in_service,
    output logic [IRQ_ID_W-1:0] o_active_id,
    output logic                o_watchdog_err
);

    localparam logic [IRQ_CNT_W-1:0] TIMEOUT_C = IRQ_CNT_W'(TIMEOUT);

    irq_state_t            r_state;
    irq_state_t            w_stateNext;
    logic [NUM_IRQ-1:0]    r_irqQ;
    logic [ADDR_W-1:0]     r_savedAddr;
    logic [IRQ_CNT_W-1:0]  r_svcCnt;
    logic [IRQ_CNT_W-1:0]  w_svcCntInc;
    logic [IRQ_ID_W-1:0]   r_activeId;
    logic                  r_watchdogErr;

    logic [NUM_IRQ-1:0]    w_pend;
    logic                  w_pendValid;
    logic [IRQ_ID_W-1:0]   w_prioIdx;
    logic [ADDR_W-1:0]     w_vecAddr;
    logic                  w_take;
    logic                  w_forceJmp;
    logic [ADDR_W-1:0]     w_forceAddr;
    logic [NUM_IRQ-1:0]    w_irqAck;

    // Arbitration works on the registered requests, so no output ever
    // depends combinationally on i_irq_req.
    assign w_pend = r_irqQ & i_irq_mask;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prioEnc (
        .i_req   (w_pend),
        .o_valid (w_pendValid),
        .o_idx   (w_prioIdx)
    );

    assign w_vecAddr = ADDR_W'(vectorAddress(32'(VECTOR_BASE), w_prioIdx,
                                             32'(VECTOR_STRIDE)));

    assign w_svcCntInc = (r_svcCnt == TIMEOUT_C) ? r_svcCnt : r_svcCnt + 1'b1;

    // Next-state and fetch-override logic. A take and an RTI can never
    // coincide: RTI is only honoured in SERVICE and takes only happen in IDLE,
    // so at least one main-line fetch separates a return from the next take.
    // Everything is forced quiet while reset is asserted so the sequencer sees
    // no override during the reset cycle itself.
    always_comb begin
        w_stateNext = r_state;
        w_take      = 1'b0;
        w_forceJmp  = 1'b0;
        w_forceAddr = '0;
        w_irqAck    = '0;

        case (r_state)
            IRQ_IDLE: begin
                if (i_global_en && i_take_ok && w_pendValid) begin
                    w_take      = 1'b1;
                    w_forceJmp  = 1'b1;
                    w_forceAddr = w_vecAddr;
                    w_stateNext = IRQ_SERVICE;
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        w_irqAck[i] = (w_prioIdx == IRQ_ID_W'(i));
                    end
                end
            end
            IRQ_SERVICE: begin
                if (i_rti) begin
                    w_forceJmp  = 1'b1;
                    w_forceAddr = r_savedAddr;
                    w_stateNext = IRQ_IDLE;
                end
            end
            default: begin
                w_stateNext = IRQ_IDLE;
            end
        endcase

        if (!i_sync_reset_n) begin
            w_take      = 1'b0;
            w_forceJmp  = 1'b0;
            w_forceAddr = '0;
            w_irqAck    = '0;
            w_stateNext = IRQ_IDLE;
        end
    end

    // State, request capture, return address and watchdog. The counter is
    // cleared on each take and saturates, so the error flag fires exactly once
    // per over-long service and then stays set until reset.
    always_ff @(posedge i_clk) begin
        if (!i_sync_reset_n) begin
            r_state       <= IRQ_IDLE;
            r_irqQ        <= '0;
            r_savedAddr   <= '0;
            r_svcCnt      <= '0;
            r_activeId    <= '0;
            r_watchdogErr <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_irqQ  <= i_irq_req;
            if (w_take) begin
                r_savedAddr <= i_next_addr;
                r_activeId  <= w_prioIdx;
                r_svcCnt    <= '0;
            end else if (r_state == IRQ_SERVICE) begin
                r_svcCnt <= w_svcCntInc;
                if (w_svcCntInc == TIMEOUT_C) begin
                    r_watchdogErr <= 1'b1;
                end
            end
        end
    end

    assign o_force_jmp    = w_forceJmp;
    assign o_force_addr   = w_forceAddr;
    assign o_irq_ack      = w_irqAck;
    assign o_in_service   = i_sync_reset_n && (r_state == IRQ_SERVICE);
    assign o_active_id    = i_sync_reset_n ? r_activeId : '0;
    assign o_watchdog_err = i_sync_reset_n && r_watchdogErr;

endmodule
